dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data RAM between the CPU MEM stage and a loader/debug port.
//   Sits between the CPU data bus (dram_we/addr/write_data/read_data) and the RAM.
//   Grants one access per cycle and stalls the CPU when the loader takes a slot.
//   Bounded-wait fairness keeps the loader from starving. A lock mode gives the loader exclusive access for program load.
// PARAMETERS
//   AW          32  address width
//   DW          32  data width
//   STARVE_MAX  4   max cycles a pending loader request waits while the CPU wins (>=1)
// PORTS
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   cpu_req    in   1   CPU MEM stage requests a load or store this cycle
//   cpu_we     in   1   CPU store enable
//   cpu_addr   in   AW  CPU address
//   cpu_wdata  in   DW  CPU store data
//   cpu_rdata  out  DW  ram_rdata passthrough, combinational
//   cpu_stall  out  1   CPU must hold its pipeline and MEM request this cycle
//   ld_req     in   1   loader request
//   ld_we      in   1   loader write enable
//   ld_addr    in   AW  loader address
//   ld_wdata   in   DW  loader write data
//   ld_lock    in   1   loader requests exclusive mode
//   ld_gnt     out  1   loader access performed this cycle
//   ld_rdata   out  DW  registered loader read data
//   ld_rvalid  out  1   ld_rdata valid, one-cycle pulse
//   ram_we     out  1   RAM write enable
//   ram_addr   out  AW  RAM address
//   ram_wdata  out  DW  RAM write data
//   ram_rdata  in   DW  RAM read data, combinational read
// BEHAVIOUR
//   - RAM model: combinational read, write on posedge clk when ram_we=1.
//   - Registered state: mode {NORMAL, LOCK}, wait counter wcnt (width clog2(STARVE_MAX+1)), ld_rdata, ld_rvalid.
//   - Reset (rst_n=0, async): mode=NORMAL, wcnt=0, ld_rdata=0, ld_rvalid=0.
//   - While rst_n=0, combinational outputs are gated: ram_we=0, ld_gnt=0, cpu_stall=0.
//   - Grant is decided combinationally each cycle.
//   - NORMAL, CPU grant: cpu_req && !(ld_req && wcnt==STARVE_MAX).
//   - NORMAL, loader grant: ld_req && !cpu_grant. cpu_stall = cpu_req && ld_gnt.
//   - NORMAL, simultaneous requests with wcnt<STARVE_MAX: the CPU wins and wcnt increments.
//   - LOCK: ld_gnt=ld_req every cycle and cpu_stall=cpu_req. The CPU never reaches the RAM.
//   - wcnt clears on ld_gnt, on ld_req=0, or in LOCK.
//   - wcnt increments when ld_req=1 and the loader is not granted. It saturates at STARVE_MAX.
//   - RAM mux: loader granted -> ld_*.
//   - RAM mux: otherwise cpu_addr/cpu_wdata, with ram_we = cpu_we && cpu_grant.
//   - No grant -> ram_we=0.
//   - Loader handshake: hold req/we/addr/wdata stable until ld_gnt=1 is sampled. Each grant covers one access.
//   - Loader read (ld_gnt && !ld_we): next cycle ld_rvalid=1 and ld_rdata = captured ram_rdata.
//   - ld_rvalid is 0 otherwise. Loader writes produce no rvalid. ld_rdata holds its value between reads.
//   - CPU contract: while cpu_stall=1 the CPU holds cpu_req/we/addr/wdata. The access completes in the first unstalled cycle.
//   - Mode: NORMAL->LOCK on the clock edge where ld_lock=1. LOCK->NORMAL on the edge where ld_lock=0.
//   - A lock change takes effect the cycle after it is sampled. The current cycle's grant is unaffected.
//   - Bounds, NORMAL: the loader waits <= STARVE_MAX cycles. The CPU stalls <= 1 of every STARVE_MAX+1 contended cycles.
//   - Reset mid-access: a pending ld_rvalid is dropped and no RAM write occurs while rst_n=0.
// TESTING
//   1. Reset with rst_n=0, cpu_req=1, cpu_we=1, ld_req=1 -> ram_we=0, ld_gnt=0, cpu_stall=0, ld_rvalid=0.
//   2. CPU store, cpu_we=1, addr=0x10, wdata=0xDEADBEEF, ld_req=0 -> ram_we=1, ram_addr=0x10, cpu_stall=0.
//      Then a CPU load at 0x10 -> cpu_rdata=0xDEADBEEF in the same cycle.
//   3. STARVE_MAX=4, cpu_req and ld_req held high from cycle 0 -> CPU granted cycles 0-3.
//      Cycle 4: ld_gnt=1 and cpu_stall=1. Cycles 5-8: CPU. Cycle 9: loader.
//   4. RAM[0x20]=0x12345678, cpu_req=0, ld_req=1, ld_we=0, ld_addr=0x20 -> ld_gnt=1 same cycle.
//      Next cycle: ld_rvalid=1, ld_rdata=0x12345678. Cycle after: ld_rvalid=0.
//   5. ld_lock=1 at cycle N, cpu_req=1 throughout -> from N+1 cpu_stall=1 and loader writes 0x0..0x3 granted back-to-back.
//      Drop ld_lock at cycle M -> from M+1 the CPU is granted and wcnt=0.
//   6. In LOCK with a loader read granted, assert rst_n=0 -> ld_rvalid=0 and mode=NORMAL immediately.
//      After release, cpu_req alone -> granted with cpu_stall=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU MEM stage and a loader/debug port
//   cpu_req/we/addr/wdata -> CPU access; cpu_rdata is ram_rdata passed through; cpu_stall holds the CPU
//   ld_req/we/addr/wdata  -> loader access; ld_gnt marks the cycle it hits the RAM
//   ld_lock               -> exclusive loader mode, takes effect the cycle after it is sampled
//   ld_rdata/ld_rvalid    -> registered loader read data, one-cycle valid pulse
//   ram_we/addr/wdata     -> RAM port (combinational read, posedge write)
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_lock,
  output logic          ld_gnt,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_rvalid,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  localparam int WW = $clog2(STARVE_MAX + 1);
  localparam logic [WW-1:0] SMAX = WW'(STARVE_MAX);
  typedef enum logic {NORMAL, LOCK} mode_t;
  mode_t mode, mode_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic cpu_grant, starved;
  assign cpu_rdata = ram_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= NORMAL;
      wcnt <= '0;
      ld_rdata <= '0;
      ld_rvalid <= 1'b0;
    end else begin
      mode <= mode_nx;
      wcnt <= wcnt_nx;
      ld_rvalid <= ld_gnt && !ld_we;
      ld_rdata <= (ld_gnt && !ld_we) ? ram_rdata : ld_rdata;
    end
  end
  // A loader that has waited STARVE_MAX cycles beats the CPU; rst_n gates every grant.
  always_comb begin
    mode_nx = ld_lock ? LOCK : NORMAL;
    starved = ld_req && (wcnt == SMAX);
    cpu_grant = rst_n && (mode == NORMAL) && cpu_req && !starved;
    ld_gnt = rst_n && ld_req && ((mode == LOCK) || !cpu_grant);
    cpu_stall = rst_n && cpu_req && ((mode == LOCK) || ld_gnt);
    ram_we = ld_gnt ? ld_we : (cpu_we && cpu_grant);
    ram_addr = ld_gnt ? ld_addr : cpu_addr;
    ram_wdata = ld_gnt ? ld_wdata : cpu_wdata;
    wcnt_nx = (!ld_req || ld_gnt || (mode == LOCK)) ? '0 : ((wcnt == SMAX) ? wcnt : wcnt + WW'(1));
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int SM = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0, ld_lock = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ld_addr = 0, ld_wdata = 0;
  logic [31:0] cpu_rdata, ld_rdata, ram_addr, ram_wdata, ram_rdata;
  logic cpu_stall, ld_gnt, ld_rvalid, ram_we;
  logic [31:0] ram [64];
  logic [31:0] mm [64];
  bit m_lock, m_rv, e_lg, e_cg, e_st, e_we;
  int m_age;
  logic [31:0] m_rd, e_addr, e_wd;
  int vectors = 0, errs = 0;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .ld_req(ld_req),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock), .ld_gnt(ld_gnt),
    .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  always #5 clk = ~clk;
  assign ram_rdata = ram[ram_addr[5:0]];
  always @(posedge clk) if (ram_we) ram[ram_addr[5:0]] <= ram_wdata;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_age = 0; m_rv = 0; m_rd = 0;
  endtask

  // Predict this cycle's grant from the arbitration rules, then compare at the negedge.
  task automatic eval();
    if (m_lock) begin
      e_lg = ld_req; e_cg = 0; e_st = cpu_req;
    end else begin
      e_lg = ld_req && (!cpu_req || m_age >= SM);
      e_cg = cpu_req && !e_lg;
      e_st = cpu_req && e_lg;
    end
    e_we = e_lg ? ld_we : (e_cg && cpu_we);
    e_addr = e_lg ? ld_addr : cpu_addr;
    e_wd = e_lg ? ld_wdata : cpu_wdata;
    if (!rst_n) begin
      e_lg = 0; e_cg = 0; e_st = 0; e_we = 0;
    end
    @(negedge clk);
    chk("ld_gnt", 32'(ld_gnt), 32'(e_lg));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_st));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ld_rvalid", 32'(ld_rvalid), 32'(m_rv));
    chk("ld_rdata", ld_rdata, m_rd);
    if (rst_n) begin
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_wd);
      chk("cpu_rdata", cpu_rdata, mm[e_addr[5:0]]);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (e_lg && !ld_we) m_rd = mm[ld_addr[5:0]];
      m_rv = e_lg && !ld_we;
      if (e_we) mm[e_addr[5:0]] = e_wd;
      m_age = (ld_req && !e_lg && !m_lock) ? ((m_age < SM) ? m_age + 1 : m_age) : 0;
      m_lock = ld_lock;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = 32'h0101_0101 * i;
      mm[i] = 32'h0101_0101 * i;
    end
    model_reset();
    // reset gating with every request asserted
    cpu_req = 1; cpu_we = 1; ld_req = 1; ld_we = 1; ld_addr = 32'h3;
    eval();
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ld_gnt", 32'(ld_gnt), 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_rvalid", 32'(ld_rvalid), 0);
    adv();
    rst_n = 1;
    // CPU store then load
    ld_req = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    eval();
    chk("st_ram_we", 32'(ram_we), 1);
    chk("st_addr", ram_addr, 32'h10);
    chk("st_stall", 32'(cpu_stall), 0);
    adv();
    cpu_we = 0;
    eval();
    chk("ld_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    adv();
    // contention: loader wins every fifth cycle
    cpu_req = 1; ld_req = 1; ld_we = 1;
    for (int c = 0; c < 10; c++) begin
      ld_addr = 32'h30 + 32'(c); ld_wdata = 32'(c);
      eval();
      chk("fair_gnt", 32'(ld_gnt), 32'(c == 4 || c == 9));
      chk("fair_stall", 32'(cpu_stall), 32'(c == 4 || c == 9));
      adv();
    end
    // CPU seeds RAM[0x20], loader reads it back
    ld_req = 0; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
    eval(); adv();
    cpu_req = 0; cpu_we = 0; ld_req = 1; ld_we = 0; ld_addr = 32'h20;
    eval();
    chk("rd_gnt", 32'(ld_gnt), 1);
    adv();
    ld_req = 0;
    eval();
    chk("rd_rvalid", 32'(ld_rvalid), 1);
    chk("rd_data", ld_rdata, 32'h1234_5678);
    adv();
    eval();
    chk("rd_rvalid_drop", 32'(ld_rvalid), 0);
    adv();
    // lock: loader writes back-to-back while the CPU stalls
    cpu_req = 1; ld_lock = 1;
    eval(); adv();
    ld_req = 1; ld_we = 1;
    for (int i = 0; i < 4; i++) begin
      ld_addr = 32'(i); ld_wdata = 32'hA0 + 32'(i);
      eval();
      chk("lock_gnt", 32'(ld_gnt), 1);
      chk("lock_stall", 32'(cpu_stall), 1);
      adv();
    end
    ld_req = 0; ld_lock = 0;
    eval();
    chk("unlock_same_cycle_stall", 32'(cpu_stall), 1);
    adv();
    eval();
    chk("unlock_stall", 32'(cpu_stall), 0);
    chk("unlock_ram_we", 32'(ram_we), 32'(cpu_we));
    adv();
    // reset mid loader read in lock
    cpu_req = 0; ld_lock = 1;
    eval(); adv();
    ld_req = 1; ld_we = 0; ld_addr = 32'h20;
    eval(); adv();
    rst_n = 0; ld_lock = 0; cpu_req = 1; cpu_we = 1;
    #1;
    chk("arst_rvalid", 32'(ld_rvalid), 0);
    chk("arst_ram_we", 32'(ram_we), 0);
    model_reset();
    eval(); adv();
    rst_n = 1; ld_req = 0;
    eval();
    chk("post_rst_stall", 32'(cpu_stall), 0);
    chk("post_rst_we", 32'(ram_we), 1);
    adv();
    // random traffic obeying both hold contracts
    for (int n = 0; n < 1500; n++) begin
      if (!(ld_req && !e_lg)) begin
        ld_req = 1'($urandom_range(0, 1)); ld_we = 1'($urandom_range(0, 1));
        ld_addr = 32'($urandom_range(0, 63)); ld_wdata = $urandom;
      end
      if (!e_st) begin
        cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 32'($urandom_range(0, 63)); cpu_wdata = $urandom;
      end
      if ($urandom_range(0, 31) == 0) ld_lock = !ld_lock;
      eval(); adv();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
